// File: rtl/mem_readback_streamer.sv
// Streams a contiguous block of memory words out over a valid/ready interface.
// Reads are throttled so the 2-entry output FIFO can never overflow under any backpressure.
module mem_readback_streamer #(
  parameter int WID_MEM   = 9,
  parameter int DEPTH_MEM = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [11:0]        base_addr,
  input  logic [12:0]        length,
  output logic               busy,
  output logic               done,
  output logic [11:0]        mem_raddr,
  input  logic [WID_MEM-1:0] mem_rdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WID_MEM-1:0] m_data,
  output logic [11:0]        m_addr,
  output logic               m_last
);

  localparam logic [11:0] LAST_ADDR = 12'(DEPTH_MEM - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t       state_reg, state_next;
  logic [12:0]  len_reg;
  logic [12:0]  issued_reg;
  logic [12:0]  accepted_reg;
  logic [11:0]  raddr_reg;

  // One read is in flight between issue and FIFO write
  logic         rd_valid_reg;
  logic         rd_last_reg;
  logic [11:0]  rd_addr_reg;

  logic [WID_MEM-1:0] fifo_data_reg [2];
  logic [11:0]        fifo_addr_reg [2];
  logic [1:0]         fifo_last_reg;
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         count_reg;

  logic        push;
  logic        pop;
  logic        issue;
  logic        issue_last;
  logic [2:0]  occupancy;
  logic [11:0] raddr_inc;

  assign m_valid   = (count_reg != 2'd0);
  assign m_data    = fifo_data_reg[rd_ptr_reg];
  assign m_addr    = fifo_addr_reg[rd_ptr_reg];
  assign m_last    = m_valid & fifo_last_reg[rd_ptr_reg];
  assign mem_raddr = raddr_reg;
  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == FINISH);

  assign push       = rd_valid_reg;
  assign pop        = m_valid & m_ready;
  assign occupancy  = {1'b0, count_reg} + {2'b00, rd_valid_reg} - {2'b00, pop};
  assign issue      = (state_reg == RUN) && (issued_reg < len_reg) && (occupancy < 3'd2);
  assign issue_last = (issued_reg == len_reg - 13'd1);
  assign raddr_inc  = (raddr_reg == LAST_ADDR) ? 12'd0 : raddr_reg + 12'd1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (length == 13'd0) ? FINISH : RUN;
      RUN:     if (pop && m_last) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // mem_raddr always holds the next address to issue, so an issue costs no extra cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_reg      <= '0;
      issued_reg   <= '0;
      accepted_reg <= '0;
      raddr_reg    <= '0;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      rd_addr_reg  <= '0;
    end else begin
      rd_valid_reg <= issue;
      if (issue) begin
        rd_last_reg <= issue_last;
        rd_addr_reg <= raddr_reg;
        raddr_reg   <= raddr_inc;
        issued_reg  <= issued_reg + 13'd1;
      end
      if (pop) begin
        accepted_reg <= accepted_reg + 13'd1;
      end
      if (state_reg == IDLE && start) begin
        len_reg      <= length;
        raddr_reg    <= base_addr;
        issued_reg   <= '0;
        accepted_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_reg[i] <= '0;
        fifo_addr_reg[i] <= '0;
      end
      fifo_last_reg <= '0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      count_reg     <= '0;
    end else begin
      if (push) begin
        fifo_data_reg[wr_ptr_reg] <= mem_rdata;
        fifo_addr_reg[wr_ptr_reg] <= rd_addr_reg;
        fifo_last_reg[wr_ptr_reg] <= rd_last_reg;
        wr_ptr_reg                <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 2'd1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_readback_streamer.sv
// Directed bench for mem_readback_streamer: a registered-read memory model plus a
// negedge beat monitor, with expected values checked by immediate assertions.
module tb_mem_readback_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic        busy;
  logic        done;
  logic [11:0] mem_raddr;
  logic [8:0]  mem_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [8:0]  m_data;
  logic [11:0] m_addr;
  logic        m_last;

  mem_readback_streamer #(.WID_MEM(9), .DEPTH_MEM(4096)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_addr    (m_addr),
    .m_last    (m_last)
  );

  initial forever #5 clk = ~clk;

  // Memory model: word i holds i mod 512, data valid one cycle after the address is sampled
  logic [8:0] mem [4096];
  initial for (int i = 0; i < 4096; i++) mem[i] = 9'(i % 512);
  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rnd_mode = 1'b0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic [8:0]  bd [$];
  logic [11:0] ba [$];
  logic        bl [$];
  int          bc [$];
  int done_cnt = 0, done_cyc = 0, busy_cnt = 0, valid_cnt = 0, stab_err = 0;
  logic        stall_prev = 1'b0;
  logic [8:0]  prev_data = '0;
  logic [11:0] prev_addr = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      bd.push_back(m_data);
      ba.push_back(m_addr);
      bl.push_back(m_last);
      bc.push_back(cyc - t0);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc - t0;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if (m_valid) valid_cnt <= valid_cnt + 1;
    if (stall_prev && (!m_valid || m_data !== prev_data || m_addr !== prev_addr || m_last !== prev_last))
      stab_err <= stab_err + 1;
    stall_prev <= m_valid && !m_ready;
    prev_data  <= m_data;
    prev_addr  <= m_addr;
    prev_last  <= m_last;
  end

  int checks = 0;
  int failures = 0;
  int bbase, dbase, vbase, ubase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start in cycle 0 and returns #1 into cycle 1
  task automatic do_start(input logic [11:0] b, input logic [12:0] l);
    @(posedge clk); #1;
    base_addr = b; length = l; start = 1'b1;
    t0 = cyc; bbase = bd.size(); dbase = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == dbase && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_done_pulses"}, 32'(done_cnt - dbase), 32'd1);
  endtask

  task automatic check_beats(input string tag, input logic [11:0] b, input int n);
    logic [11:0] a;
    chk({tag, "_beats"}, 32'(bd.size() - bbase), 32'(n));
    for (int i = 0; i < n && bbase + i < bd.size(); i++) begin
      a = b + 12'(i);
      chk({tag, "_addr"}, 32'(ba[bbase + i]), 32'(a));
      chk({tag, "_data"}, 32'(bd[bbase + i]), 32'(a % 12'd512));
      chk({tag, "_last"}, 32'(bl[bbase + i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy",   32'(busy),      32'd0);
    chk("rst_done",   32'(done),      32'd0);
    chk("rst_valid",  32'(m_valid),   32'd0);
    chk("rst_last",   32'(m_last),    32'd0);
    chk("rst_raddr",  32'(mem_raddr), 32'd0);
    chk("rst_data",   32'(m_data),    32'd0);
    chk("rst_addr",   32'(m_addr),    32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic run: beats in cycles 3..6, done in cycle 7
    do_start(12'h000, 13'd4);
    chk("s1_raddr_c1", 32'(mem_raddr), 32'h000);
    chk("s1_busy_c1",  32'(busy),      32'd1);
    wait_done("s1", 100);
    check_beats("s1", 12'h000, 4);
    for (int i = 0; i < 4 && bbase + i < bc.size(); i++)
      chk("s1_beat_cycle", 32'(bc[bbase + i]), 32'(3 + i));
    chk("s1_done_cycle", 32'(done_cyc), 32'd7);

    // Address wrap at the top of memory
    do_start(12'hFFE, 13'd4);
    wait_done("s2", 100);
    check_beats("s2", 12'hFFE, 4);
    chk("s2_addr2", 32'(ba[bbase + 2]), 32'h000);
    chk("s2_data0", 32'(bd[bbase]), 32'd510);

    // Random backpressure
    rnd_mode = 1'b1;
    do_start(12'h100, 13'd16);
    wait_done("s3", 1000);
    rnd_mode = 1'b0;
    check_beats("s3", 12'h100, 16);
    chk("s3_stall_stable", 32'(stab_err), 32'd0);

    // Zero length: straight to FINISH
    @(posedge clk); #1;
    ubase = busy_cnt; vbase = valid_cnt;
    do_start(12'h123, 13'd0);
    chk("s4_done_c1", 32'(done), 32'd1);
    chk("s4_busy_c1", 32'(busy), 32'd0);
    wait_done("s4", 20);
    repeat (3) @(posedge clk); #1;
    chk("s4_done_cycle", 32'(done_cyc), 32'd1);
    chk("s4_busy_seen",  32'(busy_cnt - ubase), 32'd0);
    chk("s4_valid_seen", 32'(valid_cnt - vbase), 32'd0);
    chk("s4_beats",      32'(bd.size() - bbase), 32'd0);

    // Second start while busy is ignored
    do_start(12'h020, 13'd8);
    @(posedge clk); #1;
    base_addr = 12'h300; length = 13'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("s5", 200);
    repeat (6) @(posedge clk); #1;
    chk("s5_single_done", 32'(done_cnt - dbase), 32'd1);
    check_beats("s5", 12'h020, 8);
    chk("s5_idle_busy", 32'(busy), 32'd0);

    // Reset mid-run aborts, then a fresh run works
    do_start(12'h040, 13'd10);
    for (int k = 0; k < 50 && bd.size() - bbase < 3; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    chk("s6_rst_busy",  32'(busy),      32'd0);
    chk("s6_rst_valid", 32'(m_valid),   32'd0);
    chk("s6_rst_raddr", 32'(mem_raddr), 32'd0);
    chk("s6_rst_data",  32'(m_data),    32'd0);
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    vbase = valid_cnt;
    repeat (6) @(posedge clk); #1;
    chk("s6_abort_beats", 32'(bd.size() - bbase), 32'd3);
    chk("s6_abort_done",  32'(done_cnt - dbase),  32'd0);
    chk("s6_stale_valid", 32'(valid_cnt - vbase), 32'd0);
    do_start(12'h200, 13'd2);
    wait_done("s6", 100);
    check_beats("s6", 12'h200, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_readback_streamer.md
MEM_READBACK_STREAMER -- requirements
Module: mem_readback_streamer

Interface
REQ-001 The module SHALL have parameter WID_MEM, default 9, meaning the memory word width in bits.
REQ-002 The module SHALL have parameter DEPTH_MEM, default 4096, meaning the number of memory words; the address width is fixed at 12 bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: single-cycle request to begin a readback.
REQ-006 The module SHALL have port base_addr, input, 12 bits: first word address, sampled with start.
REQ-007 The module SHALL have port length, input, 13 bits: word count 0..4096, sampled with start.
REQ-008 The module SHALL have port busy, output, 1 bit: a readback is in progress.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse at the end of a readback.
REQ-010 The module SHALL have port mem_raddr, output, 12 bits: registered read address to the memory.
REQ-011 The module SHALL have port mem_rdata, input, WID_MEM bits: memory read data, valid one cycle after mem_raddr is sampled.
REQ-012 The module SHALL have port m_valid, output, 1 bit: stream beat valid.
REQ-013 The module SHALL have port m_ready, input, 1 bit: stream sink ready.
REQ-014 The module SHALL have port m_data, output, WID_MEM bits: memory word.
REQ-015 The module SHALL have port m_addr, output, 12 bits: address of the word on m_data.
REQ-016 The module SHALL have port m_last, output, 1 bit: high on the final beat of a readback.

Function
REQ-017 The control FSM SHALL have states IDLE, RUN and FINISH.
REQ-018 In IDLE, start=1 SHALL latch base_addr and length and move to RUN; if length=0, it SHALL instead move to FINISH.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 busy SHALL be 1 in RUN and 0 in IDLE and FINISH.
REQ-021 FINISH SHALL last exactly one cycle, drive done=1, then return to IDLE.
REQ-022 A read SHALL be issued in a RUN cycle only if words remain unissued and (fifo_count + inflight − pop) < 2, where pop = m_valid & m_ready.
REQ-023 Issue addresses SHALL be base_addr, base_addr+1, …, each taken modulo DEPTH_MEM; an address of DEPTH_MEM−1 SHALL wrap to 0.
REQ-024 Read latency SHALL be 2 cycles from issue to FIFO write; with start in cycle 0, mem_raddr=base_addr in cycle 1 and m_valid=1 carrying that word in cycle 3.
REQ-025 Output buffering SHALL be a 2-entry FIFO holding data, address and last flag.
REQ-026 With m_ready held high, throughput SHALL be one beat per cycle with no gaps.
REQ-027 The FIFO SHALL never overflow or drop a word under any m_ready pattern.
REQ-028 m_data, m_addr and m_last SHALL remain stable while m_valid=1 and m_ready=0.
REQ-029 m_last SHALL be 1 only on beat number length.
REQ-030 RUN SHALL move to FINISH in the cycle after the m_last beat handshakes.
REQ-031 A FIFO push and pop in the same cycle SHALL leave the count unchanged.
REQ-032 An internal 13-bit counter SHALL track issued words, and a separate 13-bit counter SHALL track accepted words.

Reset
REQ-033 When reset=0, the module SHALL immediately force the FSM to IDLE and the FIFO and both counters to empty or zero.
REQ-034 While reset=0, the outputs SHALL be busy=0, done=0, m_valid=0, m_last=0, mem_raddr=0, m_data=0 and m_addr=0.
REQ-035 A reset asserted mid-readback SHALL abort the readback; no done pulse SHALL be generated and no stale beat SHALL appear after reset release.

Verification
REQ-036 Scenario: memory preloaded with word i = i mod 512, base=0x000, length=4, m_ready=1 -> m_valid in cycles 3–6 with data 0,1,2,3, m_last on data 3, done pulse in cycle 7.
REQ-037 Scenario: base=0xFFE, length=4 -> m_addr sequence 0xFFE, 0xFFF, 0x000, 0x001 with matching data.
REQ-038 Scenario: length=16 with m_ready toggled randomly 50% -> exactly 16 beats in order, no duplicates, m_data stable under stall.
REQ-039 Scenario: length=0 -> busy never 1, done=1 in cycle 1, m_valid never 1.
REQ-040 Scenario: second start pulsed in cycle 2 of a length=8 run -> ignored; exactly 8 beats and a single done pulse.
REQ-041 Scenario: reset=0 asserted after beat 3 of length=10, then released, then a new start with length=2 -> no done for the aborted run, exactly 2 beats for the new run.
